mem_system: RTL and testbench

MEM_SYSTEM -- requirements
Module: mem_system

---
 rtl/mem_system_if.sv | 26 ++
 rtl/mem_system.sv | 159 +++++++++++++++
 tb/tb_mem_system.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_system_if.sv
// mem_system_if: request/response bus of the cached memory system.
//   master (requester) drives Addr, DataIn, Rd, Wr, createdump and
//   observes DataOut, Done, Stall, CacheHit, err.
//   slave (mem_system) is the mirror image.
interface mem_system_if;
   logic [15:0] Addr;
   logic [15:0] DataIn;
   logic        Rd;
   logic        Wr;
   logic        createdump;
   logic [15:0] DataOut;
   logic        Done;
   logic        Stall;
   logic        CacheHit;
   logic        err;

   modport master (
      output Addr, DataIn, Rd, Wr, createdump,
      input  DataOut, Done, Stall, CacheHit, err
   );

   modport slave (
      input  Addr, DataIn, Rd, Wr, createdump,
      output DataOut, Done, Stall, CacheHit, err
   );
endinterface

// File: rtl/mem_system.sv
// mem_system: direct-mapped, write-back, write-allocate cache (256 lines x
// 4 x 16-bit words) in front of a 4-bank, 32K-word backing store with a
// 2-cycle read latency.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset (clears valid/dirty, aborts misses)
//   bus  - mem_system_if.slave: Addr/DataIn/Rd/Wr/createdump in,
//          DataOut/Done/Stall/CacheHit/err out
// Latency from the accepting edge: hit 0 extra edges, clean miss 7, dirty 11.
module mem_system (
   input  logic         clk,
   input  logic         rst,
   mem_system_if.slave  bus
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_LOOKUP = 4'd1;
   localparam logic [3:0] S_WB0    = 4'd2;
   localparam logic [3:0] S_WB3    = 4'd5;
   localparam logic [3:0] S_RD0    = 4'd6;
   localparam logic [3:0] S_RD3    = 4'd9;
   localparam logic [3:0] S_WAIT1  = 4'd10;
   localparam logic [3:0] S_WAIT2  = 4'd11;
   localparam logic [3:0] S_DONE   = 4'd12;

   logic [3:0]  state_q, state_d;

   // registered request
   logic [15:0] addr_q, din_q;
   logic        rd_q, wr_q;

   // cache arrays
   logic [255:0]     valid_q, dirty_q;
   logic [4:0]       tag_arr_q [256];
   logic [3:0][15:0] line_q    [256];

   // backing store: bank = word offset, row = {tag, index}
   logic [15:0] mem_q [4][8192];

   // fill return pipeline: a word issued in RDn lands two cycles later
   logic [1:0]       vld_pipe_q;
   logic [1:0][1:0]  wd_pipe_q;
   logic [1:0][15:0] rdata_pipe_q;

   logic [4:0] tag;
   logic [7:0] idx;
   logic [1:0] off;
   logic       bad, hit, in_lookup, in_done, lookup_ok;
   logic       done, stall, accept, cpu_write;
   logic       is_wb, is_rd;
   logic [3:0] wb_step, rd_step;
   logic [1:0] seq_word;
   logic       unused_dump;

   assign tag = addr_q[15:11];
   assign idx = addr_q[10:3];
   assign off = addr_q[2:1];

   assign bad       = (rd_q & wr_q) | addr_q[0];
   assign hit       = valid_q[idx] && (tag_arr_q[idx] == tag);
   assign in_lookup = (state_q == S_LOOKUP);
   assign in_done   = (state_q == S_DONE);
   assign lookup_ok = in_lookup & (bad | hit);
   assign done      = lookup_ok | in_done;
   assign stall     = !((state_q == S_IDLE) | lookup_ok | in_done);
   assign accept    = !stall & (bus.Rd | bus.Wr) & !rst;
   // an illegal request never reaches DONE, so bad only matters in LOOKUP
   assign cpu_write = wr_q & !bad & ((in_lookup & hit) | in_done);

   assign is_wb    = (state_q >= S_WB0) && (state_q <= S_WB3);
   assign is_rd    = (state_q >= S_RD0) && (state_q <= S_RD3);
   assign wb_step  = state_q - S_WB0;
   assign rd_step  = state_q - S_RD0;
   assign seq_word = is_wb ? wb_step[1:0] : rd_step[1:0];

   assign unused_dump = bus.createdump;

   assign bus.Done     = done;
   assign bus.Stall    = stall;
   assign bus.CacheHit = in_lookup & hit & !bad;
   assign bus.err      = in_lookup & bad;
   assign bus.DataOut  = (done & rd_q & !bad) ? line_q[idx][off] : 16'h0000;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_LOOKUP;
         S_LOOKUP: begin
            if (bad | hit)
               state_d = accept ? S_LOOKUP : S_IDLE;
            else if (valid_q[idx] & dirty_q[idx])
               state_d = S_WB0;
            else
               state_d = S_RD0;
         end
         S_DONE:   state_d = accept ? S_LOOKUP : S_IDLE;
         default: begin
            // WB0..WB3, RD0..RD3, WAIT1, WAIT2 are encoded consecutively,
            // WB3 falls into RD0 and WAIT2 into DONE
            if (state_q >= S_WB0 && state_q <= S_WAIT2)
               state_d = state_q + 4'd1;
            else
               state_d = S_IDLE;
         end
      endcase
   end

   // control state and per-line flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         valid_q    <= '0;
         dirty_q    <= '0;
         vld_pipe_q <= '0;
         addr_q     <= '0;
         din_q      <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         vld_pipe_q <= {vld_pipe_q[0], is_rd};
         if (accept) begin
            addr_q <= bus.Addr;
            din_q  <= bus.DataIn;
            rd_q   <= bus.Rd;
            wr_q   <= bus.Wr;
         end
         if (state_q == S_WAIT2) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end
         if (cpu_write)
            dirty_q[idx] <= 1'b1;
      end
   end

   // data/tag arrays and backing store carry no reset; rst only blocks
   // updates so an aborted miss leaves nothing behind that matters
   always_ff @(posedge clk) begin
      if (is_rd) begin
         rdata_pipe_q[0] <= mem_q[seq_word][{tag, idx}];
         wd_pipe_q[0]    <= seq_word;
      end
      rdata_pipe_q[1] <= rdata_pipe_q[0];
      wd_pipe_q[1]    <= wd_pipe_q[0];

      if (!rst) begin
         if (vld_pipe_q[1])
            line_q[idx][wd_pipe_q[1]] <= rdata_pipe_q[1];
         if (cpu_write)
            line_q[idx][off] <= din_q;
         if (state_q == S_WAIT2)
            tag_arr_q[idx] <= tag;
         if (is_wb)
            mem_q[seq_word][{tag_arr_q[idx], idx}] <= line_q[idx][seq_word];
      end
   end

endmodule

// File: tb/tb_mem_system.sv
module tb_mem_system;
   bit   clk = 1'b0;
   logic rst;
   int   tests_run = 0;
   int   fails = 0;

   mem_system_if bus ();
   mem_system u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   // reference model: backing store plus cache line bookkeeping
   bit [15:0] bmem    [32768];
   bit [15:0] m_line  [256][4];
   bit [4:0]  m_tag   [256];
   bit        m_valid [256];
   bit        m_dirty [256];

   function automatic void model_reset();
      for (int i = 0; i < 256; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
   endfunction

   function automatic void model_op(input bit rd, input bit wr, input logic [15:0] a,
                                    input logic [15:0] d, output int lat,
                                    output logic [15:0] dout, output logic hit);
      bit [7:0] idx = a[10:3];
      bit [4:0] tg  = a[15:11];
      bit [1:0] w   = a[2:1];
      lat = 0; dout = 16'h0000; hit = 1'b0;
      if ((rd && wr) || a[0]) return;
      if (m_valid[idx] && m_tag[idx] == tg) hit = 1'b1;
      else begin
         if (m_valid[idx] && m_dirty[idx]) begin
            lat = 11;
            for (int i = 0; i < 4; i++) bmem[{m_tag[idx], idx, 2'(i)}] = m_line[idx][i];
         end else lat = 7;
         for (int i = 0; i < 4; i++) m_line[idx][i] = bmem[{tg, idx, 2'(i)}];
         m_tag[idx] = tg; m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0;
      end
      if (wr) begin
         m_line[idx][w] = d;
         m_dirty[idx] = 1'b1;
      end else dout = m_line[idx][w];
   endfunction

   // present a request at the next edge (caller guarantees Stall=0), then
   // wait (bounded) for Done; lat = edges after the accepting edge
   task automatic req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      output int lat, output logic [15:0] dout, output logic hit,
                      output logic e, output int stl);
      bus.Rd = rd; bus.Wr = wr; bus.Addr = a; bus.DataIn = d;
      @(posedge clk); #1;
      bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = 16'($urandom); bus.DataIn = 16'($urandom);
      lat = 0; stl = 0;
      while (bus.Done !== 1'b1 && lat < 40) begin
         if (bus.Stall === 1'b1) stl++;
         @(posedge clk); #1;
         lat++;
      end
      dout = bus.DataOut; hit = bus.CacheHit; e = bus.err;
   endtask

   task automatic do_reset();
      bus.Rd = 1'b0; bus.Wr = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   int lat, stl, elat;
   logic [15:0] dout, edout;
   logic hit, e, ehit;

   task automatic test_reset();
      rst = 1'b1; bus.Rd = 1'b1; bus.Addr = 16'h6000;
      repeat (2) @(posedge clk);
      #1;
      bus.Rd = 1'b0;
      tests_run++;
      if (bus.Done !== 0 || bus.Stall !== 0 || bus.CacheHit !== 0 || bus.err !== 0 || bus.DataOut !== 16'h0) begin
         fails++;
         $display("FAIL reset_outputs: Done=%b Stall=%b Hit=%b err=%b DataOut=%h, want all 0",
                  bus.Done, bus.Stall, bus.CacheHit, bus.err, bus.DataOut);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_clean_miss_hit();
      req(1, 0, 16'h6000, 16'h0, lat, dout, hit, e, stl); model_op(1, 0, 16'h6000, 16'h0, elat, edout, ehit);
      tests_run++;
      if (lat !== 7 || dout !== 16'h0000 || hit !== 0 || e !== 0 || stl !== 7) begin
         fails++;
         $display("FAIL rd6000_miss: lat=%0d dout=%h hit=%b err=%b stall=%0d, want 7 0000 0 0 7", lat, dout, hit, e, stl);
      end
      req(1, 0, 16'h6000, 16'h0, lat, dout, hit, e, stl); model_op(1, 0, 16'h6000, 16'h0, elat, edout, ehit);
      tests_run++;
      if (lat !== 0 || dout !== 16'h0000 || hit !== 1 || e !== 0 || stl !== 0) begin
         fails++;
         $display("FAIL rd6000_hit: lat=%0d dout=%h hit=%b err=%b stall=%0d, want 0 0000 1 0 0", lat, dout, hit, e, stl);
      end
   endtask

   task automatic test_write_miss();
      do_reset();
      req(0, 1, 16'h6002, 16'hBEEF, lat, dout, hit, e, stl); model_op(0, 1, 16'h6002, 16'hBEEF, elat, edout, ehit);
      tests_run++;
      if (lat !== 7 || dout !== 16'h0000 || hit !== 0 || e !== 0 || stl !== 7) begin
         fails++;
         $display("FAIL wr6002_miss: lat=%0d dout=%h hit=%b err=%b stall=%0d, want 7 0000 0 0 7", lat, dout, hit, e, stl);
      end
      req(1, 0, 16'h6002, 16'h0, lat, dout, hit, e, stl); model_op(1, 0, 16'h6002, 16'h0, elat, edout, ehit);
      tests_run++;
      if (lat !== 0 || dout !== 16'hBEEF || hit !== 1 || e !== 0) begin
         fails++;
         $display("FAIL rd6002_hit: lat=%0d dout=%h hit=%b err=%b, want 0 beef 1 0", lat, dout, hit, e);
      end
   endtask

   task automatic test_dirty_miss();
      req(1, 0, 16'hE002, 16'h0, lat, dout, hit, e, stl); model_op(1, 0, 16'hE002, 16'h0, elat, edout, ehit);
      tests_run++;
      if (lat !== 11 || dout !== 16'h0000 || hit !== 0 || e !== 0 || stl !== 11) begin
         fails++;
         $display("FAIL rdE002_dirty: lat=%0d dout=%h hit=%b err=%b stall=%0d, want 11 0000 0 0 11", lat, dout, hit, e, stl);
      end
      req(1, 0, 16'h6002, 16'h0, lat, dout, hit, e, stl); model_op(1, 0, 16'h6002, 16'h0, elat, edout, ehit);
      tests_run++;
      if (lat !== 7 || dout !== 16'hBEEF || hit !== 0 || e !== 0) begin
         fails++;
         $display("FAIL rd6002_refill: lat=%0d dout=%h hit=%b err=%b, want 7 beef 0 0", lat, dout, hit, e);
      end
   endtask

   task automatic test_err();
      req(1, 0, 16'h6001, 16'h0, lat, dout, hit, e, stl); model_op(1, 0, 16'h6001, 16'h0, elat, edout, ehit);
      tests_run++;
      if (lat !== 0 || dout !== 16'h0000 || hit !== 0 || e !== 1 || stl !== 0) begin
         fails++;
         $display("FAIL err_odd: lat=%0d dout=%h hit=%b err=%b stall=%0d, want 0 0000 0 1 0", lat, dout, hit, e, stl);
      end
      req(1, 1, 16'h6000, 16'hFFFF, lat, dout, hit, e, stl); model_op(1, 1, 16'h6000, 16'hFFFF, elat, edout, ehit);
      tests_run++;
      if (lat !== 0 || dout !== 16'h0000 || hit !== 0 || e !== 1) begin
         fails++;
         $display("FAIL err_rdwr: lat=%0d dout=%h hit=%b err=%b, want 0 0000 0 1", lat, dout, hit, e);
      end
      req(1, 0, 16'h6000, 16'h0, lat, dout, hit, e, stl); model_op(1, 0, 16'h6000, 16'h0, elat, edout, ehit);
      tests_run++;
      if (lat !== 0 || dout !== 16'h0000 || hit !== 1 || e !== 0) begin
         fails++;
         $display("FAIL after_err: lat=%0d dout=%h hit=%b err=%b, want 0 0000 1 0", lat, dout, hit, e);
      end
   endtask

   task automatic test_reset_abort();
      int dn, st;
      do_reset();
      bus.Rd = 1'b1; bus.Addr = 16'h6000;
      @(posedge clk); #1;
      bus.Rd = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      tests_run++;
      if (bus.Stall !== 1 || bus.Done !== 0) begin
         fails++;
         $display("FAIL in_rd2: Stall=%b Done=%b, want 1 0", bus.Stall, bus.Done);
      end
      rst = 1'b1; bus.Rd = 1'b1; bus.Addr = 16'h6000;
      @(posedge clk); #1;
      rst = 1'b0; bus.Rd = 1'b0;
      model_reset();
      tests_run++;
      if (bus.Stall !== 0 || bus.Done !== 0 || bus.CacheHit !== 0 || bus.DataOut !== 16'h0) begin
         fails++;
         $display("FAIL abort_outputs: Stall=%b Done=%b Hit=%b DataOut=%h, want 0 0 0 0000",
                  bus.Stall, bus.Done, bus.CacheHit, bus.DataOut);
      end
      dn = 0; st = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.Done === 1'b1) dn++;
         if (bus.Stall === 1'b1) st++;
      end
      tests_run++;
      if (dn !== 0 || st !== 0) begin
         fails++;
         $display("FAIL abort_quiet: done_cycles=%0d stall_cycles=%0d, want 0 0", dn, st);
      end
      req(1, 0, 16'h6000, 16'h0, lat, dout, hit, e, stl); model_op(1, 0, 16'h6000, 16'h0, elat, edout, ehit);
      tests_run++;
      if (lat !== 7 || hit !== 0 || dout !== 16'h0000 || stl !== 7) begin
         fails++;
         $display("FAIL abort_rerun: lat=%0d hit=%b dout=%h stall=%0d, want 7 0 0000 7", lat, hit, dout, stl);
      end
   endtask

   task automatic test_back_to_back();
      req(0, 1, 16'h6004, 16'h1234, lat, dout, hit, e, stl); model_op(0, 1, 16'h6004, 16'h1234, elat, edout, ehit);
      req(1, 0, 16'h6004, 16'h0, lat, dout, hit, e, stl); model_op(1, 0, 16'h6004, 16'h0, elat, edout, ehit);
      tests_run++;
      if (lat !== 0 || hit !== 1 || dout !== 16'h1234) begin
         fails++;
         $display("FAIL b2b_hit_rd: lat=%0d hit=%b dout=%h, want 0 1 1234", lat, hit, dout);
      end
      req(0, 1, 16'h0840, 16'hA5A5, lat, dout, hit, e, stl); model_op(0, 1, 16'h0840, 16'hA5A5, elat, edout, ehit);
      tests_run++;
      if (lat !== 7 || hit !== 0) begin
         fails++;
         $display("FAIL b2b_wr_miss: lat=%0d hit=%b, want 7 0", lat, hit);
      end
      req(1, 0, 16'h0840, 16'h0, lat, dout, hit, e, stl); model_op(1, 0, 16'h0840, 16'h0, elat, edout, ehit);
      tests_run++;
      if (lat !== 0 || hit !== 1 || dout !== 16'hA5A5) begin
         fails++;
         $display("FAIL b2b_after_done: lat=%0d hit=%b dout=%h, want 0 1 a5a5", lat, hit, dout);
      end
      req(1, 0, 16'h8840, 16'h0, lat, dout, hit, e, stl); model_op(1, 0, 16'h8840, 16'h0, elat, edout, ehit);
      req(1, 0, 16'h0840, 16'h0, lat, dout, hit, e, stl); model_op(1, 0, 16'h0840, 16'h0, elat, edout, ehit);
      tests_run++;
      if (lat !== 7 || hit !== 0 || dout !== 16'hA5A5) begin
         fails++;
         $display("FAIL b2b_evict_reload: lat=%0d hit=%b dout=%h, want 7 0 a5a5", lat, hit, dout);
      end
   endtask

   task automatic test_random();
      bit wr;
      logic [15:0] a, d;
      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom_range(0, 1));
         a  = {5'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 2'($urandom), 1'b0};
         d  = 16'($urandom);
         bus.createdump = 1'($urandom);
         model_op(!wr, wr, a, d, elat, edout, ehit);
         req(!wr, wr, a, d, lat, dout, hit, e, stl);
         tests_run++;
         if (lat !== elat || dout !== edout || hit !== ehit || e !== 0 || stl !== elat) begin
            fails++;
            $display("FAIL rand%0d %s %h: lat=%0d dout=%h hit=%b err=%b stall=%0d, want %0d %h %b 0 %0d",
                     n, wr ? "wr" : "rd", a, lat, dout, hit, e, stl, elat, edout, ehit, elat);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) bmem[i] = 16'h0;
      model_reset();
      bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = 16'h0; bus.DataIn = 16'h0; bus.createdump = 1'b0;
      test_reset();
      test_clean_miss_hit();
      test_write_miss();
      test_dirty_miss();
      test_err();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
